// File: rtl/nfc_ecc_fix.sv
// nfc_ecc_fix: applies ECC decoder error locations to the page buffer by read-modify-write.
module nfc_ecc_fix #(
    parameter int ECC_AWID   = 12,
    parameter int DAT_WID    = 16,
    parameter int BUF_AWID   = 8,
    parameter int DATA_BYTES = 512,
    parameter int MAX_ERR    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ecc_dec_rdy,
    input  logic [3:0]          ecc_err_cnt,
    input  logic                ecc_uncor,
    output logic                mem_if_rd,
    input  logic [ECC_AWID-1:0] mem_dec_addr,
    output logic                buf_rd,
    output logic                buf_wr,
    output logic [BUF_AWID-1:0] buf_addr,
    input  logic [DAT_WID-1:0]  buf_rdat,
    output logic [DAT_WID-1:0]  buf_wdat,
    output logic                fix_busy,
    output logic                fix_done,
    output logic                fix_fail,
    output logic [3:0]          fix_cnt
);
    typedef enum logic [2:0] {IDLE, CHK, LOAD, RD, WAIT1, WAIT2, WR, DONE} state_t;
    state_t state, state_nxt;
    logic [ECC_AWID-1:0] addr_q;
    logic [3:0]          ent_cnt;
    logic [DAT_WID-1:0]  rdat_q;
    logic                uncor_q;
    logic                chk_fail;
    logic                skip;
    logic                last;
    logic                in_rmw;
    assign chk_fail = uncor_q || (32'(ecc_err_cnt) > MAX_ERR);
    // Entries beyond the data region land in parity/spare and are not corrected.
    assign skip     = 32'(mem_dec_addr[ECC_AWID-1:3]) >= DATA_BYTES;
    assign last     = (ent_cnt + 4'd1) == ecc_err_cnt;
    assign in_rmw   = (state == RD) || (state == WAIT1) || (state == WAIT2) || (state == WR);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ecc_dec_rdy ? CHK : IDLE;
            CHK:     state_nxt = (chk_fail || ecc_err_cnt == 4'd0) ? DONE : LOAD;
            LOAD:    state_nxt = skip ? (last ? DONE : LOAD) : RD;
            RD:      state_nxt = WAIT1;
            WAIT1:   state_nxt = WAIT2;
            WAIT2:   state_nxt = WR;
            WR:      state_nxt = (ent_cnt == ecc_err_cnt) ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    assign mem_if_rd = state == LOAD;
    assign buf_rd    = state == RD;
    assign buf_wr    = state == WR;
    assign buf_addr  = in_rmw ? addr_q[ECC_AWID-1:4] : '0;
    assign buf_wdat  = (state == WR) ? rdat_q ^ ({{(DAT_WID-1){1'b0}}, 1'b1} << addr_q[3:0]) : '0;
    assign fix_busy  = state != IDLE;
    assign fix_done  = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            ent_cnt  <= '0;
            rdat_q   <= '0;
            uncor_q  <= 1'b0;
            fix_fail <= 1'b0;
            fix_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && ecc_dec_rdy) begin
                ent_cnt  <= '0;
                uncor_q  <= ecc_uncor;
                fix_fail <= 1'b0;
                fix_cnt  <= '0;
            end
            if (state == CHK && chk_fail)
                fix_fail <= 1'b1;
            if (state == LOAD) begin
                addr_q  <= mem_dec_addr;
                ent_cnt <= ent_cnt + 4'd1;
            end
            // Registered RAM data is valid in WAIT2, two cycles after the read strobe.
            if (state == WAIT2)
                rdat_q <= buf_rdat;
            if (state == WR)
                fix_cnt <= (fix_cnt == 4'hF) ? 4'hF : fix_cnt + 4'd1;
        end
    end
endmodule
